ex_fwd_stage: RTL
=================

# ex_fwd_stage

Execute-stage register and ALU for the 5-stage MIPS pipeline. It is the producer of the 38-bit EX→ID forwarding bus consumed by the register file's read-bypass path. The block latches decoded operands from ID, computes the ALU result, and drives the bypass bus and the EX→MEM bus. It also detects load-use hazards, raising a hold request to IF/ID and inserting a bubble into EX.

## Interface
Parameters: none.

Clock is `clk`. Reset is `rst`, synchronous and active-high.

- `clk` in 1: pipeline clock; all state updates on the posedge.
- `rst` in 1: synchronous, active-high reset.
- `stall_ex` in 1: global stall; EX register holds its contents.
- `flush` in 1: squash; EX becomes a bubble.
- `id_valid` in 1: ID presents a real instruction.
- `id_rf_we` in 1: instruction writes the register file.
- `id_rf_waddr` in 5: destination register.
- `id_is_load` in 1: instruction is a load; `result` is then the memory address.
- `id_alu_op` in 4: ALU operation code (encoding under Operation).
- `id_src_a`, `id_src_b` in 32 each: operands, already forwarded and selected by ID.
- `id_raddr1`, `id_raddr2` in 5 each: source registers of the instruction currently in ID.
- `id_re1`, `id_re2` in 1 each: the corresponding source register is actually read.
- `id_hold` out 1: load-use hold request to IF/ID.
- `ex_to_id_bus` out 38: `{ex_rf_we, ex_rf_waddr[4:0], ex_result[31:0]}`, MSB first.
- `ex_to_mem_bus` out 39: `{ex_is_load, ex_rf_we, ex_rf_waddr[4:0], ex_result[31:0]}`.

## Operation
**EX register contents:** `valid`, `rf_we`, `waddr`, `is_load`, `alu_op`, `src_a`, `src_b`. Reset clears all of them to 0.

**Next-state priority, evaluated each posedge:**
1. `rst`: clear everything.
2. `flush`: `valid`←0, all other fields ←0.
3. `stall_ex`: hold all fields.
4. `id_hold`: insert a bubble, identical to case 2.
5. Otherwise capture the `id_*` inputs; `valid`←`id_valid`.

**ALU (combinational on registered operands):**
- 0 ADD, 1 SUB: modulo 2^32, no overflow trap.
- 2 AND, 3 OR, 4 XOR.
- 5 SLT (signed), 6 SLTU: result is 32'd1 or 32'd0.
- 7 SLL, 8 SRL, 9 SRA: `src_b` shifted by `src_a[4:0]`.
- 10 LUI: `{src_b[15:0], 16'h0}`.
- 11 PASS: `src_a`.
- 12–15: result 32'h0.

**Effective write enable:** `eff_we = valid & rf_we & (waddr != 0)`.

**`ex_to_id_bus` fields:**
- we = `eff_we & ~is_load`. A load's data is not yet known, so it is never bypassed from EX.
- waddr = `waddr` when `valid`, else 0.
- result = ALU result when `valid`, else 0.

**`ex_to_mem_bus` fields:**
- `is_load` gated by `valid`.
- we = `eff_we`.
- waddr and result as on `ex_to_id_bus`.

**Load-use hazard:**
- `id_hold = valid & is_load & eff_we & ((id_re1 & id_raddr1==waddr) | (id_re2 & id_raddr2==waddr))`.
- When high, IF/ID freeze externally. EX takes a bubble next cycle (priority 4), so the load advances to MEM and `id_hold` drops.
- If `stall_ex` is also high, the load stays in EX and `id_hold` stays high.

**Hazard FSM**, derived from registered state:
- NORMAL → BUBBLE when `id_hold & ~stall_ex & ~flush`.
- BUBBLE → NORMAL on the following cycle.
- `flush` in any state → NORMAL with a bubble.

## Timing
- **Reset:** during and after `rst`, all outputs are 0 (`ex_to_id_bus`=38'h0, `ex_to_mem_bus`=39'h0, `id_hold`=0).
- **Latency:** an instruction captured at edge N drives both buses during cycle N..N+1, i.e. one-cycle ID→EX latency. The result is combinational from the EX register; no extra register.
- **Hold timing:** `id_hold` is combinational, valid in the same cycle the dependent instruction sits in ID.
- **Load-use penalty:** exactly one bubble per load-use pair (absent `stall_ex`).
- **Mid-hazard `rst`:** FSM returns to NORMAL, bubble cleared, `id_hold`=0 next cycle.
- **`flush` with `id_hold`:** `flush` wins; EX becomes a bubble and `id_hold` drops next cycle.
- **`waddr`=0:** never raises `we` on either bus and never raises `id_hold`.

## Test plan
- **Reset:** assert `rst` 2 cycles with random `id_*` → both buses 0, `id_hold`=0; the first capture after release appears at the next edge.
- **ALU ops:**
  - ADD 32'hFFFF_FFFF+1 → 0.
  - SUB 0−1 → FFFF_FFFF.
  - SLT 32'h8000_0000 vs 1 → 1; SLTU same operands → 0.
  - SRA 32'h8000_0000 by 4 → F800_0000.
  - LUI 32'h1234 → 1234_0000.
  - Each result is expected on `ex_to_id_bus[31:0]` with `we`=1, `waddr`=5'd8.
- **Load-use:** load to $9 captured, then ID presents `id_raddr1`=9, `id_re1`=1 → `id_hold`=1 and `ex_to_id_bus` `we`=0 that cycle; next cycle EX is a bubble (bus=0) and `id_hold`=0. Same case with `id_re1`=0 → no hold.
- **Stall:** `stall_ex` for 3 cycles with an ADD in EX → bus value unchanged all 3 cycles. With a load-use pending and `stall_ex`=1, `id_hold` stays 1 until `stall_ex` drops, then one bubble follows.
- **Flush and `$0`:** `flush` in the same cycle as `id_hold` → next cycle EX is a bubble and `id_hold`=0. ADD with `waddr`=0 → `we`=0 on both buses.

Source files
------------

// File: rtl/ex_fwd_stage.sv
// ex_fwd_stage: MIPS execute-stage register, ALU, EX->ID bypass bus and load-use hold.
module ex_fwd_stage (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall_ex,
  input  logic        flush,
  input  logic        id_valid,
  input  logic        id_rf_we,
  input  logic [4:0]  id_rf_waddr,
  input  logic        id_is_load,
  input  logic [3:0]  id_alu_op,
  input  logic [31:0] id_src_a,
  input  logic [31:0] id_src_b,
  input  logic [4:0]  id_raddr1,
  input  logic [4:0]  id_raddr2,
  input  logic        id_re1,
  input  logic        id_re2,
  output logic        id_hold,
  output logic [37:0] ex_to_id_bus,
  output logic [38:0] ex_to_mem_bus
);
  typedef enum logic {NORMAL, BUBBLE} state_t;
  state_t state, state_nx;
  logic valid, rf_we, is_load, eff_we;
  logic [4:0] waddr, out_waddr;
  logic [3:0] alu_op;
  logic [31:0] src_a, src_b, alu, out_result;
  always_ff @(posedge clk)
    if (rst || flush || (!stall_ex && id_hold)) begin
      valid   <= 1'b0;
      rf_we   <= 1'b0;
      waddr   <= 5'd0;
      is_load <= 1'b0;
      alu_op  <= 4'd0;
      src_a   <= 32'h0;
      src_b   <= 32'h0;
    end else if (!stall_ex) begin
      valid   <= id_valid;
      rf_we   <= id_rf_we;
      waddr   <= id_rf_waddr;
      is_load <= id_is_load;
      alu_op  <= id_alu_op;
      src_a   <= id_src_a;
      src_b   <= id_src_b;
    end
  always_ff @(posedge clk)
    state <= rst ? NORMAL : state_nx;
  always_comb
    state_nx = (state == NORMAL && id_hold && !stall_ex && !flush) ? BUBBLE : NORMAL;
  always_comb begin
    alu = 32'h0;
    case (alu_op)
      4'd0:  alu = src_a + src_b;
      4'd1:  alu = src_a - src_b;
      4'd2:  alu = src_a & src_b;
      4'd3:  alu = src_a | src_b;
      4'd4:  alu = src_a ^ src_b;
      4'd5:  alu = {31'h0, $signed(src_a) < $signed(src_b)};
      4'd6:  alu = {31'h0, src_a < src_b};
      4'd7:  alu = src_b << src_a[4:0];
      4'd8:  alu = src_b >> src_a[4:0];
      4'd9:  alu = $signed(src_b) >>> src_a[4:0];
      4'd10: alu = {src_b[15:0], 16'h0};
      4'd11: alu = src_a;
      default: alu = 32'h0;
    endcase
  end
  assign eff_we     = valid & rf_we & (waddr != 5'd0);
  assign out_waddr  = valid ? waddr : 5'd0;
  assign out_result = valid ? alu : 32'h0;
  // A bubble always follows the BUBBLE entry, so holding only from NORMAL loses nothing.
  assign id_hold = (state == NORMAL) & valid & is_load & eff_we &
                   ((id_re1 & (id_raddr1 == waddr)) | (id_re2 & (id_raddr2 == waddr)));
  assign ex_to_id_bus  = {eff_we & ~is_load, out_waddr, out_result};
  assign ex_to_mem_bus = {valid & is_load, eff_we, out_waddr, out_result};
endmodule
